// File: rtl/run_ctrl.sv
// run_ctrl -- run sequencer and data-memory port arbiter for the 9-bit core.
//
// Holds the core in reset while the host owns dat_mem. A rising edge on req
// starts a run: one START cycle with the core still in reset, then RUN with
// the memory port handed to the core. A run ends when prog_ctr reaches
// DONE_PC or when the executed-cycle watchdog expires. The core is then
// frozen, the memory port goes back to the host and done is raised.
//
// Ports
//   clk, reset                  rising-edge clock, async active-high reset
//   req                         host start request (level, rising edge acts)
//   prog_ctr                    core program counter
//   core_rst, core_en           core synchronous reset / advance enable
//   core_mwe/maddr/mwdat        core store port
//   host_mreq/we/addr/wdat      host memory access request
//   host_gnt                    host access accepted this cycle
//   mem_we/mem_addr/mem_wdat    muxed port to dat_mem
//   done, timeout, cyc_cnt      run status and executed-cycle count

module run_ctrl #(
   parameter int D       = 12,
   parameter int AW      = 8,
   parameter int DW      = 8,
   parameter int CW      = 16,
   parameter int DONE_PC = 128,
   parameter int MAX_CYC = 4096
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   input  logic [D-1:0]  prog_ctr,
   output logic          core_rst,
   output logic          core_en,
   input  logic          core_mwe,
   input  logic [AW-1:0] core_maddr,
   input  logic [DW-1:0] core_mwdat,
   input  logic          host_mreq,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdat,
   output logic          host_gnt,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdat,
   output logic          done,
   output logic          timeout,
   output logic [CW-1:0] cyc_cnt
);

   localparam logic [D-1:0]  PC_END   = D'(DONE_PC);
   localparam logic [CW-1:0] CYC_LAST = CW'(MAX_CYC - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state;
   state_t state_nx;

   logic req_q;
   logic req_rise;
   logic pc_hit;
   logic wd_hit;
   logic host_own;

   assign req_rise = req & ~req_q;
   assign pc_hit   = (prog_ctr == PC_END);
   // Watchdog fires on the cycle that executes the MAX_CYC-th instruction;
   // a PC match in the same cycle takes priority.
   assign wd_hit   = ~pc_hit & (cyc_cnt == CYC_LAST);

   // ------------------------------------------------------------------
   // Registered state and run status
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         req_q   <= 1'b0;
         done    <= 1'b0;
         timeout <= 1'b0;
         cyc_cnt <= '0;
      end else begin
         state <= state_nx;
         req_q <= req;
         case (state)
            START: begin
               cyc_cnt <= '0;
               done    <= 1'b0;
               timeout <= 1'b0;
            end
            RUN: begin
               if (core_en) begin
                  cyc_cnt <= cyc_cnt + 1'b1;
               end
               if (pc_hit) begin
                  done    <= 1'b1;
                  timeout <= 1'b0;
               end else if (wd_hit) begin
                  done    <= 1'b1;
                  timeout <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Next state and core control
   // ------------------------------------------------------------------
   always_comb begin
      state_nx = state;
      core_rst = 1'b0;
      core_en  = 1'b0;
      host_own = 1'b0;
      case (state)
         IDLE: begin
            core_rst = 1'b1;
            host_own = 1'b1;
            if (req_rise) begin
               state_nx = START;
            end
         end
         START: begin
            core_rst = 1'b1;
            state_nx = RUN;
         end
         RUN: begin
            // Never execute the instruction sitting at DONE_PC.
            core_en = ~pc_hit;
            if (pc_hit || wd_hit) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            host_own = 1'b1;
            if (req_rise) begin
               state_nx = START;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Memory port mux: host in IDLE/DONE, core in START/RUN.
   // core_en is low in START, so no store leaks out before RUN.
   // ------------------------------------------------------------------
   always_comb begin
      host_gnt = 1'b0;
      mem_we   = 1'b0;
      mem_addr = core_maddr;
      mem_wdat = core_mwdat;
      if (host_own) begin
         host_gnt = host_mreq;
         mem_we   = host_mreq & host_we;
         mem_addr = host_addr;
         mem_wdat = host_wdat;
      end else begin
         mem_we   = core_mwe & core_en;
      end
   end

endmodule

// File: tb/tb_run_ctrl.sv
module tb_run_ctrl;

   localparam int D       = 12;
   localparam int AW      = 8;
   localparam int DW      = 8;
   localparam int CW      = 16;
   localparam int DONE_PC = 128;
   localparam int MAXA    = 4096;
   localparam int MAXB    = 20;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_a, req_b;
   logic [D-1:0]  prog_ctr;
   logic          core_mwe;
   logic [AW-1:0] core_maddr;
   logic [DW-1:0] core_mwdat;
   logic          host_mreq, host_we;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdat;

   logic          a_core_rst, a_core_en, a_host_gnt, a_mem_we, a_done, a_timeout;
   logic [AW-1:0] a_mem_addr;
   logic [DW-1:0] a_mem_wdat;
   logic [CW-1:0] a_cyc_cnt;
   logic          b_core_rst, b_core_en, b_host_gnt, b_mem_we, b_done, b_timeout;
   logic [AW-1:0] b_mem_addr;
   logic [DW-1:0] b_mem_wdat;
   logic [CW-1:0] b_cyc_cnt;

   always #5 clk = ~clk;

   run_ctrl #(.D(D), .AW(AW), .DW(DW), .CW(CW), .DONE_PC(DONE_PC), .MAX_CYC(MAXA)) dut_a (
      .clk(clk), .reset(reset), .req(req_a), .prog_ctr(prog_ctr),
      .core_rst(a_core_rst), .core_en(a_core_en),
      .core_mwe(core_mwe), .core_maddr(core_maddr), .core_mwdat(core_mwdat),
      .host_mreq(host_mreq), .host_we(host_we), .host_addr(host_addr), .host_wdat(host_wdat),
      .host_gnt(a_host_gnt), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdat(a_mem_wdat),
      .done(a_done), .timeout(a_timeout), .cyc_cnt(a_cyc_cnt));

   run_ctrl #(.D(D), .AW(AW), .DW(DW), .CW(CW), .DONE_PC(DONE_PC), .MAX_CYC(MAXB)) dut_b (
      .clk(clk), .reset(reset), .req(req_b), .prog_ctr(prog_ctr),
      .core_rst(b_core_rst), .core_en(b_core_en),
      .core_mwe(core_mwe), .core_maddr(core_maddr), .core_mwdat(core_mwdat),
      .host_mreq(host_mreq), .host_we(host_we), .host_addr(host_addr), .host_wdat(host_wdat),
      .host_gnt(b_host_gnt), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdat(b_mem_wdat),
      .done(b_done), .timeout(b_timeout), .cyc_cnt(b_cyc_cnt));

   // Expected outputs of one DUT for one clock cycle.
   typedef struct {
      int            dut;
      logic          rst, en, gnt, we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdat;
      logic          done, to;
      logic [CW-1:0] cyc;
   } cyc_exp_t;

   // Expected outcome of one completed run.
   typedef struct {
      int            dut;
      logic          to;
      logic [CW-1:0] cyc;
   } res_t;

   cyc_exp_t cq[$];
   res_t     rq[$];
   int vectors     = 0;
   int miscompares = 0;

   // Reference model: per-DUT run status as the host sees it.
   bit            m_idle [2];
   logic          m_done [2];
   logic          m_to   [2];
   logic [CW-1:0] m_cyc  [2];
   int            m_max  [2];

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         m_idle[k] = 1'b1;
         m_done[k] = 1'b0;
         m_to[k]   = 1'b0;
         m_cyc[k]  = '0;
      end
   endfunction

   // Host-owned cycle (IDLE or DONE): port follows the host, status held.
   function automatic cyc_exp_t host_exp(int k);
      cyc_exp_t e;
      e.dut  = k;
      e.rst  = m_idle[k];
      e.en   = 1'b0;
      e.gnt  = host_mreq;
      e.we   = host_mreq & host_we;
      e.addr = host_addr;
      e.wdat = host_wdat;
      e.done = m_done[k];
      e.to   = m_to[k];
      e.cyc  = m_cyc[k];
      return e;
   endfunction

   task automatic set_req(int k, logic v);
      if (k == 0) req_a = v;
      else        req_b = v;
   endtask

   task automatic drive_rand(int hmode);
      core_mwe   = 1'($urandom);
      core_maddr = AW'($urandom);
      core_mwdat = DW'($urandom);
      prog_ctr   = D'($urandom);
      host_mreq  = (hmode == 1) ? 1'b1 : 1'($urandom);
      host_we    = (hmode == 1) ? 1'b1 : 1'($urandom);
      host_addr  = AW'($urandom);
      host_wdat  = DW'($urandom);
   endtask

   task automatic idle_cycles(int k, int n, int hmode, logic rlvl);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         drive_rand(hmode);
         req_a = 1'b0;
         req_b = 1'b0;
         set_req(k, rlvl);
         cq.push_back(host_exp(k));
      end
   endtask

   // kind 0: PC counts 0,1,2..; kind 1: PC stuck at 5;
   // kind 2: random PCs with DONE_PC at run cycle hit_at.
   // abort_at >= 0 asserts reset in that run cycle.
   task automatic do_run(int k, int kind, int hit_at, int req_hold, int hmode, int abort_at);
      cyc_exp_t      e;
      logic [D-1:0]  pc;
      logic [CW-1:0] c;
      logic          to;
      bit            fin;
      int            i;
      // request edge, still host-owned
      @(posedge clk); #1;
      reset = 1'b0;
      drive_rand(hmode);
      set_req(k, 1'b1);
      cq.push_back(host_exp(k));
      // START: core held in reset, no write, no grant
      @(posedge clk); #1;
      drive_rand(hmode);
      if (req_hold <= 1) set_req(k, 1'b0);
      e = '{dut: k, rst: 1'b1, en: 1'b0, gnt: 1'b0, we: 1'b0, addr: core_maddr,
            wdat: core_mwdat, done: m_done[k], to: m_to[k], cyc: m_cyc[k]};
      cq.push_back(e);
      m_idle[k] = 1'b0;
      c   = '0;
      to  = 1'b0;
      fin = 1'b0;
      i   = 0;
      while (!fin) begin
         @(posedge clk); #1;
         drive_rand(hmode);
         if (i + 2 >= req_hold) set_req(k, 1'b0);
         case (kind)
            0:       pc = D'(i);
            1:       pc = D'(5);
            default: begin
               if (i == hit_at) pc = D'(DONE_PC);
               else begin
                  pc = D'($urandom);
                  while (pc == D'(DONE_PC)) pc = D'($urandom);
               end
            end
         endcase
         prog_ctr = pc;
         if (i == abort_at) begin
            #1 reset = 1'b1;
            model_reset();
            cq.push_back(host_exp(k));
            return;
         end
         e = '{dut: k, rst: 1'b0, en: (pc != D'(DONE_PC)), gnt: 1'b0,
               we: core_mwe & (pc != D'(DONE_PC)), addr: core_maddr, wdat: core_mwdat,
               done: 1'b0, to: 1'b0, cyc: c};
         cq.push_back(e);
         if (pc == D'(DONE_PC)) begin
            fin = 1'b1;
         end else begin
            if (int'(c) == m_max[k] - 1) begin
               fin = 1'b1;
               to  = 1'b1;
            end
            c = c + 1'b1;
         end
         i++;
      end
      m_done[k] = 1'b1;
      m_to[k]   = to;
      m_cyc[k]  = c;
      rq.push_back('{dut: k, to: to, cyc: c});
   endtask

   // ------------------------------------------------------------------
   // Monitor: per-cycle outputs and run completions
   // ------------------------------------------------------------------
   logic prev_done [2] = '{1'b0, 1'b0};

   always @(negedge clk) begin
      cyc_exp_t e;
      res_t     r;
      logic     dn;
      while (cq.size() > 0) begin
         e = cq.pop_front();
         chk($sformatf("core_rst[%0d]", e.dut), (e.dut == 0) ? a_core_rst : b_core_rst, e.rst);
         chk($sformatf("core_en[%0d]", e.dut),  (e.dut == 0) ? a_core_en  : b_core_en,  e.en);
         chk($sformatf("host_gnt[%0d]", e.dut), (e.dut == 0) ? a_host_gnt : b_host_gnt, e.gnt);
         chk($sformatf("mem_we[%0d]", e.dut),   (e.dut == 0) ? a_mem_we   : b_mem_we,   e.we);
         chk($sformatf("mem_addr[%0d]", e.dut), (e.dut == 0) ? a_mem_addr : b_mem_addr, e.addr);
         chk($sformatf("mem_wdat[%0d]", e.dut), (e.dut == 0) ? a_mem_wdat : b_mem_wdat, e.wdat);
         chk($sformatf("done[%0d]", e.dut),     (e.dut == 0) ? a_done     : b_done,     e.done);
         chk($sformatf("timeout[%0d]", e.dut),  (e.dut == 0) ? a_timeout  : b_timeout,  e.to);
         chk($sformatf("cyc_cnt[%0d]", e.dut),  (e.dut == 0) ? a_cyc_cnt  : b_cyc_cnt,  e.cyc);
      end
      for (int k = 0; k < 2; k++) begin
         dn = (k == 0) ? a_done : b_done;
         if (dn === 1'b1 && prev_done[k] !== 1'b1) begin
            if (rq.size() == 0) begin
               chk($sformatf("unexpected_done[%0d]", k), 32'd1, 32'd0);
            end else begin
               r = rq.pop_front();
               chk("run_dut", k, r.dut);
               chk($sformatf("run_timeout[%0d]", k), (k == 0) ? a_timeout : b_timeout, r.to);
               chk($sformatf("run_cyc_cnt[%0d]", k), (k == 0) ? a_cyc_cnt : b_cyc_cnt, r.cyc);
            end
         end
         prev_done[k] = dn;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, got running expected finished");
      $fatal(1, "time limit expired");
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      m_max[0] = MAXA;
      m_max[1] = MAXB;
      model_reset();
      reset      = 1'b1;
      req_a      = 1'b0;
      req_b      = 1'b0;
      prog_ctr   = '0;
      core_mwe   = 1'b0;
      core_maddr = '0;
      core_mwdat = '0;
      host_mreq  = 1'b0;
      host_we    = 1'b0;
      host_addr  = '0;
      host_wdat  = '0;

      // reset state of both instances
      @(posedge clk); #1;
      cq.push_back(host_exp(0));
      cq.push_back(host_exp(1));
      @(posedge clk); #1;
      reset = 1'b0;

      // host write 0x10 <= 0xA5 while idle
      @(posedge clk); #1;
      host_mreq = 1'b1;
      host_we   = 1'b1;
      host_addr = 8'h10;
      host_wdat = 8'hA5;
      cq.push_back(host_exp(0));

      // PC walks 0..128, run ends on DONE_PC with cyc_cnt=128
      do_run(0, 0, 0, 1, 0, -1);
      idle_cycles(0, 3, 0, 1'b0);

      // host holds a write request through the whole run
      do_run(0, 2, 40, 3, 1, -1);
      idle_cycles(0, 2, 1, 1'b0);

      // watchdog: PC stuck, 20 executed cycles
      do_run(1, 1, 0, 1, 0, -1);
      idle_cycles(1, 3, 0, 1'b0);

      // PC match exactly when cyc_cnt=19 beats the watchdog
      do_run(1, 2, 19, 1, 0, -1);
      idle_cycles(1, 3, 0, 1'b0);

      // PC match on the very first run cycle
      do_run(0, 2, 0, 2, 0, -1);
      idle_cycles(0, 2, 0, 1'b0);

      // randomized runs on both instances
      for (int n = 0; n < 24; n++) begin
         int k;
         k = int'($urandom_range(0, 1));
         do_run(k, 2, int'($urandom_range(0, (k == 0) ? 300 : 30)),
                int'($urandom_range(1, 5)), int'($urandom_range(0, 1)), -1);
         idle_cycles(k, int'($urandom_range(1, 4)), 0, 1'b0);
      end

      // async reset mid-run with req held high, then exactly one new run
      do_run(0, 2, 100000, 1000000, 0, 7);
      @(posedge clk); #1;
      drive_rand(0);
      cq.push_back(host_exp(0));
      do_run(0, 0, 0, 1000000, 0, -1);
      idle_cycles(0, 6, 0, 1'b1);
      idle_cycles(0, 2, 0, 1'b0);

      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pending_runs", rq.size(), 0);
      chk("pending_cycles", cq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
